// File: rtl/ddr_line_fetch_if.sv
// rtl/ddr_line_fetch_if.sv - line-fetch start, DDR read port and pixel FIFO bundle
// master = fetch engine side, slave = fill FSM / memory port / FIFO side.
interface ddr_line_fetch_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int SPACE_WIDTH = 11
);
  logic                   go_fill_fifo;
  logic [31:0]            ddr_addr_to_read;
  logic [15:0]            num_pixels_per_line;
  logic [2:0]             num_bytes_per_pixel;
  logic                   rd_req;
  logic [31:0]            rd_addr;
  logic                   rd_ack;
  logic [DATA_WIDTH-1:0]  rd_data;
  logic                   rd_data_valid;
  logic [SPACE_WIDTH-1:0] fifo_space;
  logic                   fifo_wr_en;
  logic [DATA_WIDTH-1:0]  fifo_wr_data;
  logic                   busy;
  logic                   line_done;
  logic                   overrun_err;
  logic                   protocol_err;

  modport master (
    input  go_fill_fifo, ddr_addr_to_read, num_pixels_per_line, num_bytes_per_pixel,
    input  rd_ack, rd_data, rd_data_valid, fifo_space,
    output rd_req, rd_addr, fifo_wr_en, fifo_wr_data,
    output busy, line_done, overrun_err, protocol_err
  );

  modport slave (
    output go_fill_fifo, ddr_addr_to_read, num_pixels_per_line, num_bytes_per_pixel,
    output rd_ack, rd_data, rd_data_valid, fifo_space,
    input  rd_req, rd_addr, fifo_wr_en, fifo_wr_data,
    input  busy, line_done, overrun_err, protocol_err
  );
endinterface

// File: rtl/ddr_line_fetch.sv
// rtl/ddr_line_fetch.sv - fetches one video line from DDR in fixed bursts into the pixel FIFO
// One outstanding burst; FIFO space is checked once before each request.
module ddr_line_fetch #(
  parameter int DATA_WIDTH  = 32,
  parameter int BURST_BEATS = 16,
  parameter int SPACE_WIDTH = 11
) (
  input  logic               clk,
  input  logic               reset,
  ddr_line_fetch_if.master   bus
);
  localparam int BURST_BYTES = BURST_BEATS * DATA_WIDTH / 8;
  localparam int BB_SHIFT    = $clog2(BURST_BYTES);
  localparam int BEAT_W      = $clog2(BURST_BEATS);

  typedef enum logic [2:0] {IDLE, WAIT_SPACE, REQ, DATA, DONE} state_t;

  state_t                state_q, state_d;
  logic [31:0]           cur_addr_q, cur_addr_d;
  logic [18:0]           bursts_q, bursts_d;
  logic [BEAT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic                  rd_req_q, rd_req_d;
  logic [31:0]           rd_addr_q, rd_addr_d;
  logic                  wr_en_q, wr_en_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  busy_q, busy_d;
  logic                  line_done_q, line_done_d;
  logic                  overrun_q, overrun_d;
  logic                  protocol_q, protocol_d;

  logic [18:0] line_bytes;
  logic [19:0] line_rounded;
  logic [18:0] bursts_calc;
  logic        space_ok;
  logic        last_beat;

  // Round the line up to whole bursts; the overfetched tail still lands in the FIFO.
  assign line_bytes   = 19'(bus.num_pixels_per_line) * 19'(bus.num_bytes_per_pixel);
  assign line_rounded = {1'b0, line_bytes} + 20'(BURST_BYTES - 1);
  assign bursts_calc  = 19'(line_rounded >> BB_SHIFT);
  assign space_ok     = 32'(bus.fifo_space) >= 32'(BURST_BEATS);
  assign last_beat    = beat_cnt_q == BEAT_W'(BURST_BEATS - 1);

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    bursts_d   = bursts_q;
    beat_cnt_d = beat_cnt_q;
    wr_en_d    = 1'b0;
    wr_data_d  = wr_data_q;
    overrun_d  = overrun_q;
    protocol_d = protocol_q;

    case (state_q)
      IDLE: begin
        if (bus.go_fill_fifo) begin
          cur_addr_d = bus.ddr_addr_to_read;
          bursts_d   = bursts_calc;
          state_d    = (bursts_calc == 19'd0) ? DONE : WAIT_SPACE;
        end
      end
      WAIT_SPACE: begin
        if (bus.rd_data_valid) protocol_d = 1'b1;
        if (space_ok) state_d = REQ;
      end
      REQ: begin
        if (bus.rd_data_valid) protocol_d = 1'b1;
        if (bus.rd_ack) begin
          beat_cnt_d = '0;
          state_d    = DATA;
        end
      end
      DATA: begin
        if (bus.rd_data_valid) begin
          wr_en_d    = 1'b1;
          wr_data_d  = bus.rd_data;
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (last_beat) begin
            cur_addr_d = cur_addr_q + 32'(BURST_BYTES);
            bursts_d   = bursts_q - 19'd1;
            state_d    = (bursts_q == 19'd1) ? DONE : WAIT_SPACE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && bus.go_fill_fifo) overrun_d = 1'b1;

    rd_req_d    = (state_d == REQ);
    rd_addr_d   = (state_d == REQ) ? cur_addr_d : rd_addr_q;
    busy_d      = (state_d != IDLE);
    line_done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      bursts_q    <= '0;
      beat_cnt_q  <= '0;
      rd_req_q    <= 1'b0;
      rd_addr_q   <= '0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      line_done_q <= 1'b0;
      overrun_q   <= 1'b0;
      protocol_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      bursts_q    <= bursts_d;
      beat_cnt_q  <= beat_cnt_d;
      rd_req_q    <= rd_req_d;
      rd_addr_q   <= rd_addr_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
      line_done_q <= line_done_d;
      overrun_q   <= overrun_d;
      protocol_q  <= protocol_d;
    end
  end

  assign bus.rd_req       = rd_req_q;
  assign bus.rd_addr      = rd_addr_q;
  assign bus.fifo_wr_en   = wr_en_q;
  assign bus.fifo_wr_data = wr_data_q;
  assign bus.busy         = busy_q;
  assign bus.line_done    = line_done_q;
  assign bus.overrun_err  = overrun_q;
  assign bus.protocol_err = protocol_q;
endmodule

// File: tb/tb_ddr_line_fetch.sv
// tb/tb_ddr_line_fetch.sv - directed bench for ddr_line_fetch (32-bit data, 16-beat bursts)
module tb_ddr_line_fetch;
  localparam int DW = 32;
  localparam int BB = 16;
  localparam int SW = 11;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ddr_line_fetch_if #(.DATA_WIDTH(DW), .SPACE_WIDTH(SW)) bus ();

  ddr_line_fetch #(.DATA_WIDTH(DW), .BURST_BEATS(BB), .SPACE_WIDTH(SW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          vecs = 0;
  int          errs = 0;
  int          nwr_at_rst = 0;
  logic [31:0] pat = 32'hC0DE0000;
  logic [31:0] wq[$];
  logic [31:0] eq[$];

  always @(negedge clk) if (bus.fifo_wr_en === 1'b1) wq.push_back(bus.fifo_wr_data);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic start(input logic [31:0] a, input logic [15:0] n, input logic [2:0] b);
    wq.delete();
    eq.delete();
    bus.ddr_addr_to_read    = a;
    bus.num_pixels_per_line = n;
    bus.num_bytes_per_pixel = b;
    bus.go_fill_fifo        = 1'b1;
    step();
    bus.go_fill_fifo        = 1'b0;
  endtask

  // Memory-port model: answers each request with BB beats; optional ack delay,
  // overrun pulse before burst ovr_at, async reset after 5 beats of burst abort_b.
  task automatic serve(input string tag, input logic [31:0] base, input int nb,
                       input int ack_dly, input int ovr_at, input int abort_b);
    logic aborted;
    aborted = 1'b0;
    for (int b = 0; b < nb; b++) begin
      if (b == ovr_at) begin
        bus.ddr_addr_to_read = 32'hDEAD0000;
        bus.go_fill_fifo     = 1'b1;
        step();
        bus.go_fill_fifo     = 1'b0;
      end
      for (int i = 0; i < 50 && bus.rd_req !== 1'b1; i++) step();
      chk({tag, " rd_req"}, 64'(bus.rd_req), 64'd1);
      chk({tag, " rd_addr"}, 64'(bus.rd_addr), 64'(base + 32'(b * 64)));
      for (int d = 0; d < ack_dly; d++) begin
        step();
        chk({tag, " req held"}, 64'(bus.rd_req), 64'd1);
        chk({tag, " addr held"}, 64'(bus.rd_addr), 64'(base + 32'(b * 64)));
      end
      bus.rd_ack = 1'b1;
      step();
      bus.rd_ack = 1'b0;
      chk({tag, " req drop"}, 64'(bus.rd_req), 64'd0);
      for (int k = 0; k < BB; k++) begin
        bus.rd_data_valid = 1'b1;
        bus.rd_data       = pat;
        if (b == abort_b && k == 5) begin
          reset = 1'b1;
          #1;
          chk({tag, " rst ctrl"}, 64'({bus.rd_req, bus.fifo_wr_en, bus.busy, bus.line_done,
                                       bus.overrun_err, bus.protocol_err}), 64'd0);
          chk({tag, " rst addr"}, 64'(bus.rd_addr), 64'd0);
          chk({tag, " rst wdata"}, 64'(bus.fifo_wr_data), 64'd0);
          #1;
          reset      = 1'b0;
          nwr_at_rst = wq.size();
          aborted    = 1'b1;
        end
        if (!aborted) eq.push_back(pat);
        pat = pat + 32'd1;
        step();
      end
      bus.rd_data_valid = 1'b0;
      if (aborted) return;
    end
  endtask

  task automatic finish_line(input string tag, input int nwrites);
    int bad;
    for (int i = 0; i < 20 && bus.line_done !== 1'b1; i++) step();
    chk({tag, " line_done"}, 64'(bus.line_done), 64'd1);
    step();
    chk({tag, " done pulse"}, 64'(bus.line_done), 64'd0);
    chk({tag, " busy low"}, 64'(bus.busy), 64'd0);
    chk({tag, " writes"}, 64'(wq.size()), 64'(nwrites));
    bad = 0;
    for (int i = 0; i < wq.size() && i < eq.size(); i++) if (wq[i] !== eq[i]) bad++;
    chk({tag, " data order"}, 64'(bad), 64'd0);
  endtask

  initial begin
    logic seen;
    reset                   = 1'b1;
    bus.go_fill_fifo        = 1'b0;
    bus.ddr_addr_to_read    = '0;
    bus.num_pixels_per_line = '0;
    bus.num_bytes_per_pixel = '0;
    bus.rd_ack              = 1'b0;
    bus.rd_data             = '0;
    bus.rd_data_valid       = 1'b0;
    bus.fifo_space          = 11'd1024;
    step();
    step();
    reset = 1'b0;
    step();
    chk("reset ctrl", 64'({bus.rd_req, bus.fifo_wr_en, bus.busy, bus.line_done,
                           bus.overrun_err, bus.protocol_err}), 64'd0);
    chk("reset addr", 64'(bus.rd_addr), 64'd0);

    // full line, 2048 B = 32 bursts
    start(32'h80000000, 16'd1024, 3'd2);
    chk("t1 busy c1", 64'(bus.busy), 64'd1);
    chk("t1 no req c1", 64'(bus.rd_req), 64'd0);
    step();
    chk("t1 req c2", 64'(bus.rd_req), 64'd1);
    serve("t1", 32'h80000000, 32, 0, -1, -1);
    finish_line("t1", 512);

    // space throttling
    bus.fifo_space = 11'd15;
    start(32'h00002000, 16'd16, 3'd2);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      seen |= bus.rd_req;
      step();
    end
    chk("t2 no req low space", 64'(seen), 64'd0);
    bus.fifo_space = 11'd16;
    for (int i = 0; i < 2 && bus.rd_req !== 1'b1; i++) step();
    chk("t2 req after space", 64'(bus.rd_req), 64'd1);
    serve("t2", 32'h00002000, 1, 0, -1, -1);
    finish_line("t2", 16);
    bus.fifo_space = 11'd1024;

    // ack withheld 5 cycles
    start(32'h00003000, 16'd32, 3'd2);
    serve("t3", 32'h00003000, 1, 5, -1, -1);
    finish_line("t3", 16);

    // overrun mid-line
    start(32'h80000000, 16'd1024, 3'd2);
    serve("t4", 32'h80000000, 32, 0, 7, -1);
    chk("t4 overrun", 64'(bus.overrun_err), 64'd1);
    finish_line("t4", 512);

    // empty line
    start(32'h00000100, 16'd0, 3'd2);
    chk("t5 done c1", 64'(bus.line_done), 64'd1);
    chk("t5 busy c1", 64'(bus.busy), 64'd1);
    chk("t5 no req", 64'(bus.rd_req), 64'd0);
    step();
    chk("t5 busy c2", 64'(bus.busy), 64'd0);
    chk("t5 done c2", 64'(bus.line_done), 64'd0);

    // 100 B -> 2 bursts with overfetch
    start(32'h00005000, 16'd50, 3'd2);
    serve("t5b", 32'h00005000, 2, 0, -1, -1);
    finish_line("t5b", 32);

    // async reset after 5 beats of burst 3
    start(32'h40000000, 16'd1024, 3'd2);
    serve("t6", 32'h40000000, 32, 0, -1, 2);
    step();
    step();
    chk("t6 late beats", 64'(wq.size()), 64'(nwr_at_rst));
    chk("t6 protocol", 64'(bus.protocol_err), 64'd0);
    chk("t6 overrun clr", 64'(bus.overrun_err), 64'd0);
    chk("t6 idle", 64'(bus.busy), 64'd0);
    start(32'h10000000, 16'd32, 3'd2);
    serve("t6b", 32'h10000000, 1, 0, -1, -1);
    finish_line("t6b", 16);

    // data while waiting for space is a protocol error
    bus.fifo_space = 11'd0;
    start(32'h00007000, 16'd32, 3'd2);
    bus.rd_data_valid = 1'b1;
    bus.rd_data       = 32'hBADBAD00;
    step();
    bus.rd_data_valid = 1'b0;
    step();
    chk("t7 protocol", 64'(bus.protocol_err), 64'd1);
    chk("t7 no write", 64'(wq.size()), 64'd0);
    bus.fifo_space = 11'd1024;
    serve("t7", 32'h00007000, 1, 0, -1, -1);
    finish_line("t7", 16);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/ddr_line_fetch.md
Name: ddr_line_fetch

Overview:
- Downstream consumer of the fill-FIFO FSM. On each go_fill_fifo pulse it latches the line start address and fetches one video line from DDR as fixed-length read bursts.
- Each returned beat is pushed into the HDMI pixel FIFO.
- Uses a req/ack command handshake toward the memory port, one outstanding burst at a time, and throttles on FIFO free space.

Parameters:
- DATA_WIDTH, 32, read data / FIFO word width in bits (32 or 64).
- BURST_BEATS, 16, beats per read burst; power of two, 2..64.
- SPACE_WIDTH, 11, width of fifo_space.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- go_fill_fifo  in  1  one-cycle start pulse from fill-FIFO FSM
- ddr_addr_to_read  in  32  line start byte address; sampled with go_fill_fifo
- num_pixels_per_line  in  16  pixels per line; sampled with go_fill_fifo
- num_bytes_per_pixel  in  3  bytes per pixel; sampled with go_fill_fifo
- rd_req  out  1  burst read request
- rd_addr  out  32  burst start byte address
- rd_ack  in  1  request accepted when rd_req && rd_ack
- rd_data  in  DATA_WIDTH  read data beat
- rd_data_valid  in  1  rd_data valid this cycle
- fifo_space  in  SPACE_WIDTH  free FIFO words
- fifo_wr_en  out  1  FIFO write strobe
- fifo_wr_data  out  DATA_WIDTH  FIFO write data
- busy  out  1  line fetch in progress
- line_done  out  1  one-cycle pulse at end of line
- overrun_err  out  1  sticky: go_fill_fifo received while busy
- protocol_err  out  1  sticky: unexpected rd_data_valid

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0.
- Constants:
  - BURST_BYTES = BURST_BEATS*DATA_WIDTH/8.
  - line_bytes = num_pixels_per_line*num_bytes_per_pixel, 19-bit unsigned.
  - bursts = ceil(line_bytes/BURST_BYTES), computed at latch.
  - Overfetch of a partial last burst is written to the FIFO.
- All outputs are registered. busy = (state != IDLE).
- IDLE:
  - go_fill_fifo latches the address into cur_addr and computes bursts.
  - bursts == 0 -> DONE; else -> WAIT_SPACE.
- WAIT_SPACE: fifo_space >= BURST_BEATS -> REQ.
- REQ:
  - rd_req = 1 and rd_addr = cur_addr, held stable until rd_ack.
  - On the ack cycle -> DATA with beat_cnt = 0. rd_req drops the cycle after ack.
- DATA:
  - Each rd_data_valid produces fifo_wr_en = 1 with fifo_wr_data = rd_data one cycle later (latency 1), and beat_cnt increments.
  - On beat BURST_BEATS-1: cur_addr += BURST_BYTES (mod 2^32 wrap) and bursts decrements. Reaching 0 -> DONE; else -> WAIT_SPACE.
- DONE: line_done = 1 for exactly one cycle -> IDLE.
- Timing:
  - go at cycle 0 -> busy = 1 at cycle 1.
  - Earliest rd_req is at cycle 2.
  - Empty line: line_done at cycle 1, busy drops at cycle 2.
- go_fill_fifo while busy (including the DONE cycle): ignored, overrun_err set; the current fetch continues unaffected.
- rd_data_valid in WAIT_SPACE or REQ: data dropped, protocol_err set. In IDLE: silently dropped, no error.
- FIFO space is checked only before each request. The FIFO must not be read-starved; fifo_space is never re-checked mid-burst.
- Async reset mid-operation: immediate return to reset values; the in-flight burst is abandoned and its late beats are dropped in IDLE. Error flags are cleared only by reset.

Test Plan:
- 1024 px x 2 B, addr 0x80000000, fifo_space 1024, rd_ack immediate -> 32 rd_req at 0x80000000, 0x80000040 ... 0x800007C0; 512 fifo_wr_en with data in order; one line_done; busy low afterward.
- fifo_space held at 15 after go -> no rd_req for 20 cycles; set to 16 -> rd_req asserted within 2 cycles.
- rd_ack withheld 5 cycles -> rd_req = 1 and rd_addr unchanged for all 5 cycles; single burst accepted; exactly 16 writes.
- Second go_fill_fifo mid-line -> overrun_err = 1; address sequence and write count identical to the first test.
- num_pixels_per_line = 0 -> line_done at cycle 1, no rd_req. 50 px x 2 B (100 B) -> 2 bursts, 32 writes.
- Reset asserted after 5 beats of burst 3 -> all outputs 0 the same cycle; remaining 11 valid beats produce no fifo_wr_en and no protocol_err; a new go restarts from the new address.
